gpio_cmd_bridge: RTL and testbench

Command/data bridge between the MicroBlaze 32-bit GPIO pair and the 2D convolution core. It decodes toggle-handshaked command words written by firmware on the GPIO output into kernel-load, pixel-load, start and soft-reset strobes, and buffers convolution results in a FIFO that firmware drains word by word through the GPIO input. It runs on the MicroBlaze-generated clock, which both the GPIO and the conv core share, so no CDC is involved.

---
 rtl/conv_bridge_pkg.sv | 27 ++
 rtl/result_fifo.sv | 70 +++++++
 rtl/gpio_cmd_bridge.sv | 171 +++++++++++++++++
 tb/tb_gpio_cmd_bridge.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/conv_bridge_pkg.sv
// Shared constants for the GPIO command bridge: opcodes, status word bit positions, FSM states.
package conv_bridge_pkg;

  localparam logic [2:0] OP_NOP         = 3'd0;
  localparam logic [2:0] OP_LOAD_KERNEL = 3'd1;
  localparam logic [2:0] OP_LOAD_PIXEL  = 3'd2;
  localparam logic [2:0] OP_START       = 3'd3;
  localparam logic [2:0] OP_READ        = 3'd4;
  localparam logic [2:0] OP_STATUS      = 3'd5;
  localparam logic [2:0] OP_SOFT_RESET  = 3'd6;
  localparam logic [2:0] OP_LOOPBACK    = 3'd7;

  localparam int ACK_BIT   = 31;
  localparam int EMPTY_BIT = 30;
  localparam int FULL_BIT  = 29;
  localparam int OVF_BIT   = 28;
  localparam int ERR_BIT   = 27;
  localparam int BUSY_BIT  = 26;
  localparam int COUNT_LSB = 21;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

endpackage

// File: rtl/result_fifo.sv
// Single-clock result FIFO with registered read; push and pop in the same cycle both
// take effect (a pop on empty returns 0 while the pushed word is kept).
module result_fifo #(
  parameter int W  = 13,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          srst,
  input  logic          i_push,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_pop,
  input  logic          i_flush,
  output logic [W-1:0]  o_rdata,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_count,
  output logic          o_drop
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [W-1:0]  r_rdata;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == DEPTH_C);
  assign w_do_pop  = i_pop && !o_empty && !i_flush;
  // A pop frees the slot this same cycle, so a push onto a full FIFO is kept then.
  assign w_do_push = i_push && !i_flush && (!o_full || w_do_pop);
  assign o_drop    = i_push && !i_flush && o_full && !w_do_pop;
  assign o_count   = r_count;
  assign o_rdata   = r_rdata;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (srst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      r_rdata <= '0;
    end else if (i_pop) begin
      r_rdata <= o_empty ? '0 : r_mem[r_rd_ptr];
    end
  end

endmodule

// File: rtl/gpio_cmd_bridge.sv
// Toggle-handshaked GPIO command decoder and result FIFO for the convolution core.
// Define GPIO_LOOPBACK_EN to make opcode 7 echo payload[12:0]; otherwise it is illegal.
module gpio_cmd_bridge
  import conv_bridge_pkg::*;
#(
  parameter int BIT_LEN   = 8,
  parameter int M_LEN     = 3,
  parameter int RAM_WIDTH = 13,
  parameter int GPIO_D    = 32,
  parameter int FIFO_AW   = 4
) (
  input  logic                     CLK100MHZ,
  input  logic                     ck_rst,
  input  logic [GPIO_D-1:0]        i_gpio_o,
  output logic [GPIO_D-1:0]        o_gpio_i,
  output logic                     o_kernel_we,
  output logic [3:0]               o_kernel_addr,
  output logic [BIT_LEN-1:0]       o_kernel_data,
  output logic                     o_pixel_valid,
  output logic [M_LEN*BIT_LEN-1:0] o_pixel_col,
  output logic                     o_start,
  output logic                     o_core_rst,
  input  logic                     i_result_valid,
  input  logic [RAM_WIDTH-1:0]     i_result,
  input  logic                     i_busy
);

  localparam int PIX_W = M_LEN * BIT_LEN;
  localparam logic [3:0] KERN_N = 4'(M_LEN * M_LEN);

  state_t               r_state, w_state_next;
  logic                 r_req_seen, r_ack;
  logic [2:0]           r_op;
  logic [27:0]          r_payload;
  logic                 r_err_pend, r_cmd_err, r_overflow;
  logic [RAM_WIDTH-1:0] r_data;
  logic                 w_new_cmd, w_exec, w_ack_st, w_op_illegal, w_unused_payload;
  logic                 w_do_kernel, w_do_pixel, w_do_start, w_do_core_rst, w_exec_err;
  logic                 w_fifo_pop, w_fifo_full, w_fifo_empty, w_fifo_drop;
  logic [FIFO_AW:0]     w_fifo_count;
  logic [RAM_WIDTH-1:0] w_fifo_rdata;

  always_ff @(posedge CLK100MHZ) begin
    if (ck_rst) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_new_cmd    = 1'b0;
    case (r_state)
      ST_IDLE: if (i_gpio_o[31] != r_req_seen) begin
        w_new_cmd    = 1'b1;
        w_state_next = ST_EXEC;
      end
      ST_EXEC: w_state_next = ST_ACK;
      ST_ACK:  w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

`ifdef GPIO_LOOPBACK_EN
  assign w_op_illegal = 1'b0;
`else
  assign w_op_illegal = (r_op == OP_LOOPBACK);
`endif

  assign w_exec        = (r_state == ST_EXEC);
  assign w_ack_st      = (r_state == ST_ACK);
  assign w_do_kernel   = w_exec && (r_op == OP_LOAD_KERNEL) && (r_payload[11:8] < KERN_N);
  assign w_do_pixel    = w_exec && (r_op == OP_LOAD_PIXEL);
  assign w_do_start    = w_exec && (r_op == OP_START) && !i_busy;
  assign w_do_core_rst = w_exec && (r_op == OP_SOFT_RESET);
  assign w_fifo_pop    = w_exec && (r_op == OP_READ);
  assign w_exec_err    = w_exec && (((r_op == OP_LOAD_KERNEL) && (r_payload[11:8] >= KERN_N)) ||
                                    ((r_op == OP_START) && i_busy) || w_op_illegal);
  assign w_unused_payload = ^r_payload;

  // Reset adopts the current toggle level so a command left on the GPIO is not replayed.
  always_ff @(posedge CLK100MHZ) begin
    if (ck_rst) begin
      r_req_seen <= i_gpio_o[31];
      r_ack      <= i_gpio_o[31];
      r_op       <= OP_NOP;
      r_payload  <= '0;
    end else begin
      if (w_new_cmd) begin
        r_req_seen <= i_gpio_o[31];
        r_op       <= i_gpio_o[30:28];
        r_payload  <= i_gpio_o[27:0];
      end
      if (w_ack_st) r_ack <= r_req_seen;
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (ck_rst) begin
      o_kernel_we   <= 1'b0;
      o_kernel_addr <= '0;
      o_kernel_data <= '0;
      o_pixel_valid <= 1'b0;
      o_pixel_col   <= '0;
      o_start       <= 1'b0;
      o_core_rst    <= 1'b0;
      r_err_pend    <= 1'b0;
    end else begin
      o_kernel_we   <= w_do_kernel;
      o_pixel_valid <= w_do_pixel;
      o_start       <= w_do_start;
      o_core_rst    <= w_do_core_rst;
      r_err_pend    <= w_exec_err;
      if (w_do_kernel) begin
        o_kernel_addr <= r_payload[11:8];
        o_kernel_data <= r_payload[BIT_LEN-1:0];
      end
      if (w_do_pixel) o_pixel_col <= r_payload[PIX_W-1:0];
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (ck_rst) begin
      r_cmd_err  <= 1'b0;
      r_overflow <= 1'b0;
      r_data     <= '0;
    end else begin
      if (w_do_core_rst)    r_overflow <= 1'b0;
      else if (w_fifo_drop) r_overflow <= 1'b1;
      if (w_ack_st) begin
        if (r_err_pend) r_cmd_err <= 1'b1;
        case (r_op)
          OP_READ: r_data <= w_fifo_rdata;
          OP_SOFT_RESET: begin
            r_cmd_err <= 1'b0;
            r_data    <= '0;
          end
`ifdef GPIO_LOOPBACK_EN
          OP_LOOPBACK: r_data <= r_payload[RAM_WIDTH-1:0];
`endif
          default: ;
        endcase
      end
    end
  end

  result_fifo #(.W(RAM_WIDTH), .AW(FIFO_AW)) u_fifo (
    .clk     (CLK100MHZ),
    .srst    (ck_rst),
    .i_push  (i_result_valid),
    .i_wdata (i_result),
    .i_pop   (w_fifo_pop),
    .i_flush (w_do_core_rst),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count),
    .o_drop  (w_fifo_drop)
  );

  always_comb begin
    o_gpio_i                          = '0;
    o_gpio_i[ACK_BIT]                 = r_ack;
    o_gpio_i[EMPTY_BIT]               = w_fifo_empty;
    o_gpio_i[FULL_BIT]                = w_fifo_full;
    o_gpio_i[OVF_BIT]                 = r_overflow;
    o_gpio_i[ERR_BIT]                 = r_cmd_err;
    o_gpio_i[BUSY_BIT]                = i_busy;
    o_gpio_i[COUNT_LSB +: FIFO_AW+1]  = w_fifo_count;
    o_gpio_i[RAM_WIDTH-1:0]           = r_data;
  end

endmodule

// File: tb/tb_gpio_cmd_bridge.sv
// Directed plus randomized bench for gpio_cmd_bridge against a queue-based reference model.
module tb_gpio_cmd_bridge;

  logic        clk;
  logic        rst;
  logic [31:0] gpio_o;
  logic [31:0] gpio_i;
  logic        kwe, pv, start, crst;
  logic [3:0]  kaddr;
  logic [7:0]  kdata;
  logic [23:0] pcol;
  logic        res_valid;
  logic [12:0] res;
  logic        busy;
  logic [3:0]  strobes;

  assign strobes = {kwe, pv, start, crst};

  gpio_cmd_bridge dut (
    .CLK100MHZ      (clk),
    .ck_rst         (rst),
    .i_gpio_o       (gpio_o),
    .o_gpio_i       (gpio_i),
    .o_kernel_we    (kwe),
    .o_kernel_addr  (kaddr),
    .o_kernel_data  (kdata),
    .o_pixel_valid  (pv),
    .o_pixel_col    (pcol),
    .o_start        (start),
    .o_core_rst     (crst),
    .i_result_valid (res_valid),
    .i_result       (res),
    .i_busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  bit          m_req, m_ack, m_ovf, m_err;
  logic [12:0] m_data;
  logic [3:0]  m_kaddr;
  logic [7:0]  m_kdata;
  logic [23:0] m_pcol;
  int          q[$];
  int          n_vec, n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_word();
    logic [31:0] w;
    int n;
    n = q.size();
    w = 32'h0;
    w[31]    = m_ack;
    w[30]    = (n == 0);
    w[29]    = (n == 16);
    w[28]    = m_ovf;
    w[27]    = m_err;
    w[26]    = busy;
    w[25:21] = 5'(n);
    w[12:0]  = m_data;
    return w;
  endfunction

  task automatic model_push(input logic [12:0] v);
    if (q.size() < 16) q.push_back(int'(v));
    else m_ovf = 1'b1;
  endtask

  task automatic chk_data_outs(input string tag);
    chk({tag, "_kaddr"}, 32'(kaddr), 32'(m_kaddr));
    chk({tag, "_kdata"}, 32'(kdata), 32'(m_kdata));
    chk({tag, "_pcol"},  32'(pcol),  32'(m_pcol));
  endtask

  task automatic idle_cycle(input bit v, input logic [12:0] val);
    res_valid = v;
    res       = val;
    @(negedge clk);
    if (v) model_push(val);
    res_valid = 1'b0;
    chk("idle_strobes", 32'(strobes), 32'h0);
    chk("idle_word", gpio_i, exp_word());
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_req = gpio_o[31]; m_ack = gpio_o[31];
    m_ovf = 0; m_err = 0; m_data = '0;
    m_kaddr = '0; m_kdata = '0; m_pcol = '0;
    q.delete();
    chk("rst_strobes", 32'(strobes), 32'h0);
    chk("rst_word", gpio_i, exp_word());
    chk_data_outs("rst");
  endtask

  task automatic do_cmd(input logic [2:0] op, input logic [27:0] pl,
                        input bit push_exec, input logic [12:0] pval);
    logic [3:0]  e_str;
    logic [12:0] popped;
    bit          err;
    e_str = 4'h0; popped = '0; err = 0;
    m_req  = ~m_req;
    gpio_o = {m_req, op, pl};
    @(negedge clk);
    chk("exec_strobes", 32'(strobes), 32'h0);
    chk("exec_ack_hold", 32'(gpio_i[31]), 32'(m_ack));
    if (push_exec) begin
      res_valid = 1'b1;
      res       = pval;
    end
    @(negedge clk);
    res_valid = 1'b0;
    case (op)
      3'd1: if (pl[11:8] < 4'd9) begin
              e_str[3] = 1'b1; m_kaddr = pl[11:8]; m_kdata = pl[7:0];
            end else err = 1;
      3'd2: begin e_str[2] = 1'b1; m_pcol = pl[23:0]; end
      3'd3: if (busy) err = 1; else e_str[1] = 1'b1;
      3'd4: if (q.size() > 0) popped = 13'(q.pop_front());
      3'd6: begin e_str[0] = 1'b1; q.delete(); m_ovf = 0; end
`ifndef GPIO_LOOPBACK_EN
      3'd7: err = 1;
`endif
      default: ;
    endcase
    if (push_exec) model_push(pval);
    chk($sformatf("op%0d_strobe", op), 32'(strobes), 32'(e_str));
    chk_data_outs($sformatf("op%0d", op));
    chk($sformatf("op%0d_live", op), gpio_i, exp_word());
    @(negedge clk);
    m_ack = m_req;
    if (err) m_err = 1;
    if (op == 3'd4) m_data = popped;
    if (op == 3'd6) begin m_err = 0; m_data = '0; end
`ifdef GPIO_LOOPBACK_EN
    if (op == 3'd7) m_data = pl[12:0];
`endif
    chk($sformatf("op%0d_ack_strobes", op), 32'(strobes), 32'h0);
    chk($sformatf("op%0d_ack_word", op), gpio_i, exp_word());
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b1; gpio_o = 32'h8000_0000;
    res_valid = 1'b0; res = '0; busy = 1'b0;
    do_reset();
    repeat (3) idle_cycle(0, '0);

    do_cmd(3'd1, 28'h000_0305, 0, '0);
    do_cmd(3'd1, 28'h000_0905, 0, '0);
    do_cmd(3'd2, 28'h011_2233, 0, '0);
    busy = 1'b1;
    do_cmd(3'd3, 28'h0, 0, '0);
    busy = 1'b0;
    do_cmd(3'd3, 28'h0, 0, '0);
    do_cmd(3'd0, 28'h0, 0, '0);

    for (int i = 1; i <= 17; i++) idle_cycle(1, 13'(i));
    do_cmd(3'd5, 28'h0, 0, '0);
    for (int i = 0; i < 17; i++) do_cmd(3'd4, 28'h0, 0, '0);

    do_cmd(3'd6, 28'h0, 0, '0);
    for (int i = 0; i < 16; i++) idle_cycle(1, 13'(16'h100 + i));
    do_cmd(3'd4, 28'h0, 1, 13'h0AA);
    do_cmd(3'd6, 28'h0, 0, '0);
    do_cmd(3'd4, 28'h0, 1, 13'h055);
    do_cmd(3'd4, 28'h0, 0, '0);

    do_cmd(3'd7, 28'h000_1ABC, 0, '0);

    // reset while a command is in flight: no strobe, no ack
    m_req  = ~m_req;
    gpio_o = {m_req, 3'd3, 28'h0};
    @(negedge clk);
    do_reset();
    repeat (2) idle_cycle(0, '0);

    for (int it = 0; it < 120; it++) begin
      logic [2:0] op;
      busy = 1'($urandom_range(0, 1));
      for (int k = 0; k < int'($urandom_range(0, 3)); k++)
        idle_cycle($urandom_range(0, 9) < 7, 13'($urandom));
      op = 3'($urandom_range(0, 7));
      do_cmd(op, 28'($urandom), (op == 3'd4) && ($urandom_range(0, 1) == 1), 13'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
